// File: rtl/cpu_regfile_pkg.sv
// cpu_regfile_pkg: shared register-file defaults, address-width helper and GPR/FPR bank settings
package cpu_regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {BANK_GPR, BANK_FPR} bank_e;

    // GPR banks hardwire register 0 to zero; FPR banks treat register 0 as ordinary storage.
    localparam int GPR_ZERO_REG = 1;
    localparam int FPR_ZERO_REG = 0;

    function automatic int aw_of(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    function automatic int zero_reg_of(input bank_e bank);
        return (bank == BANK_GPR) ? GPR_ZERO_REG : FPR_ZERO_REG;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with flush > reserve > release > hold priority
module regfile_scoreboard
    import cpu_regfile_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = GPR_ZERO_REG,
    localparam int AW      = aw_of(NREG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    output logic [NREG-1:0]   busy_d,
    output logic [NREG-1:0]   busy_q
);

    logic [NREG-1:0] rel;
    logic [NREG-1:0] rsv_mask;

    // Next scoreboard: a new reservation beats a same-cycle release, flush beats everything.
    always_comb begin
        rel = '0;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p]) rel[wr_addr[p*AW +: AW]] = 1'b1;
        rsv_mask = rsv_en ? (NREG'(1) << rsv_addr) : '0;
        busy_d   = flush ? '0 : ((busy_q & ~rel) | rsv_mask);
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // Busy flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) busy_q <= '0;
        else       busy_q <= busy_d;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with byte writes, optional zero register and write bypass
module regfile_mp
    import cpu_regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = GPR_ZERO_REG,
    parameter int BYPASS   = 1,
    localparam int AW      = aw_of(NREG)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR-1:0]      wr_byte,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy_d;

    regfile_scoreboard #(
        .NREG     (NREG),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .busy_d   (busy_d),
        .busy_q   (busy_vec)
    );

    // Post-edge array image; later ports overwrite earlier ones whole, byte merges use the stored value.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p])
                mem_d[wr_addr[p*AW +: AW]] = wr_byte[p]
                    ? {mem_q[wr_addr[p*AW +: AW]][XLEN-1:8], wr_data[p*XLEN +: 8]}
                    : wr_data[p*XLEN +: XLEN];
        if (ZERO_REG != 0) mem_d[0] = '0;
    end

    // Register array, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

    // Read ports: post-edge values when bypassing, stored values otherwise; forced quiet during reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data[i*XLEN +: XLEN] = (!rstn || (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0)) ? '0
                                    : (BYPASS != 0) ? mem_d[rd_addr[i*AW +: AW]]
                                    : mem_q[rd_addr[i*AW +: AW]];
            rd_busy[i] = rstn && ((BYPASS != 0) ? busy_d[rd_addr[i*AW +: AW]] : busy_vec[rd_addr[i*AW +: AW]]);
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table plus scoreboard-checked random run on GPR/bypass and FPR/no-bypass builds
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [14:0] rd_addr = '0;
    logic [95:0] rd_data_a, rd_data_b;
    logic [2:0]  rd_busy_a, rd_busy_b;
    logic [1:0]  wr_en = '0, wr_byte = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rsv_en = 1'b0, flush = 1'b0;
    logic [4:0]  rsv_addr = '0;
    logic [31:0] busy_vec_a, busy_vec_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(3), .NWR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_a)
    );

    regfile_mp #(.XLEN(32), .NREG(32), .NRD(3), .NWR(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_byte(wr_byte), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_b)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  we, wb;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        rsv;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  rda;
        logic [31:0] exp_d;
        logic        exp_b;
        logic [31:0] exp_bv;
    } vec_t;

    typedef struct {
        logic [95:0] da, db;
        logic [2:0]  ba, bb;
        logic [31:0] va, vb;
    } exp_t;

    vec_t tv[11];
    exp_t exp_q[$];

    // Reference model: index 0 = GPR with bypass, index 1 = FPR without bypass.
    logic [31:0] m [2][32];
    logic        b [2][32];

    function automatic logic [31:0] nxt_val(input int c, input int a);
        logic [31:0] v = m[c][a];
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_addr[p*5 +: 5] == a)
                v = wr_byte[p] ? {m[c][a][31:8], wr_data[p*32 +: 8]} : wr_data[p*32 +: 32];
        if (c == 0 && a == 0) v = '0;
        return v;
    endfunction

    function automatic logic nxt_busy(input int c, input int a);
        logic nb = b[c][a];
        logic written = 1'b0;
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_addr[p*5 +: 5] == a) written = 1'b1;
        if (flush) nb = 1'b0;
        else if (rsv_en && rsv_addr == a) nb = 1'b1;
        else if (written) nb = 1'b0;
        if (c == 0 && a == 0) nb = 1'b0;
        return nb;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            int a = int'(rd_addr[i*5 +: 5]);
            e.da[i*32 +: 32] = nxt_val(0, a);
            e.ba[i]          = nxt_busy(0, a);
            e.db[i*32 +: 32] = m[1][a];
            e.bb[i]          = b[1][a];
        end
        for (int k = 0; k < 32; k++) begin
            e.va[k] = b[0][k];
            e.vb[k] = b[1][k];
        end
        return e;
    endfunction

    task automatic model_step();
        logic [31:0] tm [2][32];
        logic        tb2 [2][32];
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 32; a++) begin
                tm[c][a]  = nxt_val(c, a);
                tb2[c][a] = nxt_busy(c, a);
            end
        m = tm;
        b = tb2;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 32; a++) begin
                m[c][a] = '0;
                b[c][a] = 1'b0;
            end
    endtask

    task automatic idle();
        wr_en = '0; wr_byte = '0; rsv_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        tv[0]  = '{2'b01, 2'b00, 5'd7, 5'd0, 32'h12345678, 32'h0,  1'b0, 5'd0, 1'b0, 5'd7, 32'h12345678, 1'b0, 32'h0};
        tv[1]  = '{2'b01, 2'b01, 5'd7, 5'd0, 32'h000000AB, 32'h0,  1'b0, 5'd0, 1'b0, 5'd7, 32'h123456AB, 1'b0, 32'h0};
        tv[2]  = '{2'b11, 2'b00, 5'd3, 5'd3, 32'h11,       32'h22, 1'b0, 5'd0, 1'b0, 5'd3, 32'h22,       1'b0, 32'h0};
        tv[3]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b0, 5'd0, 1'b0, 5'd3, 32'h22,       1'b0, 32'h0};
        tv[4]  = '{2'b01, 2'b00, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,  1'b1, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 32'h0};
        tv[5]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b1, 5'd9, 1'b0, 5'd9, 32'h0,        1'b1, 32'h200};
        tv[6]  = '{2'b01, 2'b00, 5'd9, 5'd0, 32'h99,       32'h0,  1'b1, 5'd9, 1'b0, 5'd9, 32'h99,       1'b1, 32'h200};
        tv[7]  = '{2'b10, 2'b00, 5'd0, 5'd9, 32'h0,        32'h5A, 1'b0, 5'd0, 1'b0, 5'd9, 32'h5A,       1'b0, 32'h0};
        tv[8]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b1, 5'd4, 1'b1, 5'd4, 32'h0,        1'b0, 32'h0};
        tv[9]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b1, 5'd4, 1'b0, 5'd4, 32'h0,        1'b1, 32'h10};
        tv[10] = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0,  1'b0, 5'd0, 1'b1, 5'd4, 32'h0,        1'b0, 32'h0};

        // Reset state.
        #12;
        chk("reset_rd_data_a", rd_data_a, 96'h0);
        chk("reset_busy_vec_a", {64'h0, busy_vec_a}, 96'h0);
        chk("reset_busy_vec_b", {64'h0, busy_vec_b}, 96'h0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table against the GPR/bypass build.
        for (int i = 0; i < 11; i++) begin
            wr_en = tv[i].we; wr_byte = tv[i].wb;
            wr_addr = {tv[i].a1, tv[i].a0}; wr_data = {tv[i].d1, tv[i].d0};
            rsv_en = tv[i].rsv; rsv_addr = tv[i].ra; flush = tv[i].fl;
            rd_addr = {10'd0, tv[i].rda};
            #3;
            chk($sformatf("vec%0d_rd_data", i), {64'h0, rd_data_a[31:0]}, {64'h0, tv[i].exp_d});
            chk($sformatf("vec%0d_rd_busy", i), {95'h0, rd_busy_a[0]}, {95'h0, tv[i].exp_b});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_busy_vec", i), {64'h0, busy_vec_a}, {64'h0, tv[i].exp_bv});
        end
        idle();
        rd_addr = {5'd3, 5'd7, 5'd0};
        #1;
        chk("fpr_r0_kept", {64'h0, rd_data_b[31:0]}, {64'h0, 32'hFFFFFFFF});
        chk("fpr_r7_byte", {64'h0, rd_data_b[63:32]}, {64'h0, 32'h123456AB});
        chk("gpr_r3_conflict", {64'h0, rd_data_a[95:64]}, {64'h0, 32'h22});

        // Reset asserted between edges while r5 holds data and is busy.
        @(posedge clk); #1;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        @(posedge clk); #1;
        idle();
        rd_addr = {10'd0, 5'd5};
        #1;
        chk("pre_reset_r5", {64'h0, rd_data_a[31:0]}, {64'h0, 32'hDEADBEEF});
        chk("pre_reset_busy5", {95'h0, busy_vec_a[5]}, 96'h1);
        rstn = 1'b0;
        #1;
        chk("mid_reset_r5_a", {64'h0, rd_data_a[31:0]}, 96'h0);
        chk("mid_reset_r5_b", {64'h0, rd_data_b[31:0]}, 96'h0);
        chk("mid_reset_busy_a", {64'h0, busy_vec_a}, 96'h0);
        @(negedge clk) rstn = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // Random run against the reference model, expectations queued at drive time.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            exp_t e;
            wr_en   = 2'($urandom);
            wr_byte = 2'($urandom);
            for (int p = 0; p < 2; p++)
                wr_addr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wr_data  = {$urandom, $urandom};
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 30) == 0);
            for (int i = 0; i < 3; i++)
                rd_addr[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            exp_q.push_back(model_exp());
            #3;
            e = exp_q.pop_front();
            chk("rand_rd_data_a", rd_data_a, e.da);
            chk("rand_rd_data_b", rd_data_b, e.db);
            chk("rand_rd_busy", {90'h0, rd_busy_b, rd_busy_a}, {90'h0, e.bb, e.ba});
            chk("rand_busy_vec", {32'h0, busy_vec_b, busy_vec_a}, {32'h0, e.vb, e.va});
            model_step();
            @(posedge clk); #1;
        end
        chk("queue_drained", 96'(exp_q.size()), 96'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
